// File: rtl/frame_rx.sv
// frame_rx: oversampling serial frame receiver.
// Frame on the line: start(0), op[0..2], cin, data[0..7], [parity], stop(1).
// Define FRAME_RX_PARITY_EN to add an even-parity bit before the stop bit.
// Without it the frame has no parity bit and parity_err is tied low.
module frame_rx #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [2:0] op,
  output logic       cout,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [7:0] HALF = 8'(BIT_CYCLES / 2);
  localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SHIFT  = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bits_q, bits_d;
  logic [11:0] shift_q, shift_d;
  logic        hold_q, hold_d;
  logic [2:0]  op_q, op_d;
  logic        cout_q, cout_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        din_meta_q, din_sync_q, din_prev_q;
  logic        mid;
  logic        payload_ok;

`ifdef FRAME_RX_PARITY_EN
  logic        perr_q, perr_d;
  logic        parity_err_q, parity_err_d;
  assign payload_ok = !perr_q;
  assign parity_err = parity_err_q;
`else
  assign payload_ok = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Sample point of the current bit period.
  assign mid = (cnt_q == HALF);

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_meta_q <= 1'b1;
      din_sync_q <= 1'b1;
      din_prev_q <= 1'b1;
    end else begin
      din_meta_q <= din;
      din_sync_q <= din_meta_q;
      din_prev_q <= din_sync_q;
    end
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bits_q      <= '0;
      shift_q     <= '0;
      hold_q      <= 1'b0;
      op_q        <= '0;
      cout_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef FRAME_RX_PARITY_EN
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      op_q        <= op_d;
      cout_q      <= cout_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef FRAME_RX_PARITY_EN
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic: bit timing, sampling, frame checks and field update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_d      = bits_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    op_d        = op_q;
    cout_d      = cout_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef FRAME_RX_PARITY_EN
    perr_d       = perr_q;
    parity_err_d = 1'b0;
`endif

    if (state_q != IDLE) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bits_d = '0;
        hold_d = 1'b0;
`ifdef FRAME_RX_PARITY_EN
        perr_d = 1'b0;
`endif
        // The edge cycle itself is count 0 of the start bit.
        if (din_prev_q && !din_sync_q) begin
          state_d = START;
          cnt_d   = 8'd1;
        end
      end
      START: begin
        if (mid) begin
          state_d = din_sync_q ? IDLE : SHIFT;
        end
      end
      SHIFT: begin
        if (mid) begin
          shift_d = {din_sync_q, shift_q[11:1]};
          bits_d  = bits_q + 4'd1;
          if (bits_q == 4'd11) begin
`ifdef FRAME_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef FRAME_RX_PARITY_EN
      PARITY: begin
        if (mid) begin
          perr_d  = ^{shift_q, din_sync_q};
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (hold_q) begin
          // Bad stop bit: stay busy until the line is released high.
          if (din_sync_q) begin
            state_d = IDLE;
          end
        end else if (mid) begin
          frame_err_d = !din_sync_q;
`ifdef FRAME_RX_PARITY_EN
          parity_err_d = perr_q;
`endif
          if (din_sync_q) begin
            state_d = IDLE;
            if (payload_ok) begin
              op_d    = shift_q[2:0];
              cout_d  = shift_q[3];
              data_d  = shift_q[11:4];
              valid_d = 1'b1;
            end
          end else begin
            hold_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign op        = op_q;
  assign cout      = cout_q;
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_frame_rx.sv
// tb_frame_rx: randomized scoreboard bench for frame_rx (BIT_CYCLES=4).
// Follows FRAME_RX_PARITY_EN in the same way as the design.
`timescale 1ns/1ps
module tb_frame_rx;
  localparam int BC = 4;
  localparam int K_RESET = 0;
  localparam int K_BUSY  = 1;
  localparam int K_DRAIN = 2;
  localparam int K_SEEN  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b1;
  logic [2:0] op;
  logic       cout;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  frame_rx #(.BIT_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .op(op), .cout(cout), .data(data),
    .valid(valid), .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       fe;
    logic       pe;
    logic [2:0] op;
    logic       c;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];

  // Reference model of the visible output fields.
  logic [2:0] m_op = '0;
  logic       m_c  = 1'b0;
  logic [7:0] m_d  = '0;

  int checks = 0;
  int errors = 0;

  int    chk_req  = 0;
  int    chk_done = 0;
  int    chk_kind = 0;
  string chk_name = "";
  logic  chk_exp  = 1'b0;
  logic  chk_act  = 1'b0;

  task automatic req_check(input int kind, input string name, input logic e, input logic a);
    chk_kind = kind;
    chk_name = name;
    chk_exp  = e;
    chk_act  = a;
    chk_req++;
    @(negedge clk);
    #1;
    @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    din = b;
    repeat (BC) @(posedge clk);
  endtask

  // nsend = 0 sends the whole frame and predicts its outcome; otherwise
  // only the first nsend bits are driven and nothing is predicted.
  task automatic send_frame(input logic [2:0] fop, input logic fc, input logic [7:0] fd,
                            input logic bad_par, input logic stop_b, input int nsend);
    logic [14:0] bits;
    logic        par;
    logic        pe;
    int          nb;
    exp_t        e;
    par = (^{fd, fc, fop}) ^ bad_par;
    bits = '0;
    bits[0] = 1'b0;
    bits[1] = fop[0];
    bits[2] = fop[1];
    bits[3] = fop[2];
    bits[4] = fc;
    for (int i = 0; i < 8; i++) bits[5 + i] = fd[i];
`ifdef FRAME_RX_PARITY_EN
    bits[13] = par;
    bits[14] = stop_b;
    nb = 15;
    pe = bad_par;
`else
    bits[13] = stop_b;
    nb = 14;
    pe = 1'b0;
`endif
    if (nsend == 0) begin
      if (stop_b && !pe) begin
        m_op = fop;
        m_c  = fc;
        m_d  = fd;
      end
      e.v  = stop_b && !pe;
      e.fe = !stop_b;
      e.pe = pe;
      e.op = m_op;
      e.c  = m_c;
      e.d  = m_d;
      exp_q.push_back(e);
    end else begin
      nb = nsend;
    end
    for (int i = 0; i < nb; i++) send_bit(bits[i]);
  endtask

  // Monitor: performs every comparison, popping the scoreboard on each pulse.
  initial begin : monitor
    logic pv, pfe, ppe;
    exp_t e;
    pv = 1'b0;
    pfe = 1'b0;
    ppe = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_req != chk_done) begin
        chk_done = chk_req;
        checks++;
        case (chk_kind)
          K_RESET: begin
            if ({busy, valid, frame_err, parity_err, op, cout, data} !== 16'h0) begin
              errors++;
              $display("FAIL %s got busy=%b valid=%b frame_err=%b parity_err=%b op=%0d cout=%b data=%h expected all zero",
                       chk_name, busy, valid, frame_err, parity_err, op, cout, data);
            end
          end
          K_BUSY: begin
            if (busy !== chk_exp) begin
              errors++;
              $display("FAIL %s got busy=%b expected %b", chk_name, busy, chk_exp);
            end
          end
          K_DRAIN: begin
            if (exp_q.size() != 0) begin
              errors++;
              $display("FAIL %s got %0d outstanding pulses expected 0", chk_name, exp_q.size());
            end
          end
          default: begin
            if (chk_act !== chk_exp) begin
              errors++;
              $display("FAIL %s got %b expected %b", chk_name, chk_act, chk_exp);
            end
          end
        endcase
      end
      if (!rst_n) begin
        pv = 1'b0;
        pfe = 1'b0;
        ppe = 1'b0;
      end else begin
        if (valid || frame_err || parity_err) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse got valid=%b frame_err=%b parity_err=%b expected no pulse",
                     valid, frame_err, parity_err);
          end else begin
            e = exp_q.pop_front();
            if ({valid, frame_err, parity_err, op, cout, data} !== {e.v, e.fe, e.pe, e.op, e.c, e.d}) begin
              errors++;
              $display("FAIL pulse got v=%b fe=%b pe=%b op=%0d c=%b d=%h expected v=%b fe=%b pe=%b op=%0d c=%b d=%h",
                       valid, frame_err, parity_err, op, cout, data, e.v, e.fe, e.pe, e.op, e.c, e.d);
            end
          end
          checks++;
          if ((valid && pv) || (frame_err && pfe) || (parity_err && ppe)) begin
            errors++;
            $display("FAIL pulse_width got a pulse lasting more than one cycle expected one cycle");
          end
        end
        pv = valid;
        pfe = frame_err;
        ppe = parity_err;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic       seen;
    logic [2:0] rop;
    logic       rc, rbad, rstop;
    logic [7:0] rd;
    int         gap;

    rst_n = 1'b0;
    din   = 1'b1;
    repeat (3) @(posedge clk);
    req_check(K_RESET, "reset_state", 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Good frame, then same frame with corrupted parity.
    send_frame(3'b011, 1'b1, 8'hA5, 1'b0, 1'b1, 0);
    repeat (3) @(posedge clk);
    req_check(K_BUSY, "idle_after_good", 1'b0, 1'b0);
    send_frame(3'b011, 1'b1, 8'hA5, 1'b1, 1'b1, 0);
    repeat (3) @(posedge clk);

    // Bad stop bit with the line held low afterwards.
    send_frame(3'b101, 1'b0, 8'h5A, 1'b0, 1'b0, 0);
    repeat (6) @(posedge clk);
    req_check(K_BUSY, "busy_while_line_low", 1'b1, 1'b0);
    din = 1'b1;
    repeat (5) @(posedge clk);
    req_check(K_BUSY, "idle_after_release", 1'b0, 1'b0);

    // One-clock glitch.
    din = 1'b0;
    @(posedge clk);
    din = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    req_check(K_SEEN, "glitch_busy_seen", 1'b1, seen);
    req_check(K_BUSY, "glitch_back_idle", 1'b0, 1'b0);

    // Back-to-back frames.
    send_frame(3'b011, 1'b1, 8'hA5, 1'b0, 1'b1, 0);
    send_frame(3'b110, 1'b0, 8'h3C, 1'b0, 1'b1, 0);
    repeat (4) @(posedge clk);

    // Reset during data bit 4, then a good frame.
    send_frame(3'b010, 1'b1, 8'hE7, 1'b0, 1'b1, 9);
    din = 1'b0;
    repeat (2) @(posedge clk);
    rst_n = 1'b0;
    din = 1'b1;
    m_op = '0;
    m_c  = 1'b0;
    m_d  = '0;
    repeat (2) @(posedge clk);
    req_check(K_RESET, "reset_midframe", 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    send_frame(3'b001, 1'b1, 8'h7E, 1'b0, 1'b1, 0);
    repeat (3) @(posedge clk);

    // Randomized frames.
    for (int n = 0; n < 24; n++) begin
      rop   = 3'($urandom);
      rc    = 1'($urandom);
      rd    = 8'($urandom);
      rbad  = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 4) != 0);
      send_frame(rop, rc, rd, rbad, rstop, 0);
      if (!rstop) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        din = 1'b1;
        repeat (4) @(posedge clk);
      end else begin
        gap = $urandom_range(0, 3);
        repeat (gap) @(posedge clk);
        if (gap >= 2) req_check(K_BUSY, "idle_between_frames", 1'b0, 1'b0);
      end
    end

    din = 1'b1;
    repeat (20) @(posedge clk);
    req_check(K_DRAIN, "all_pulses_seen", 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
